// File: rtl/bfloat_pkg.sv
// Shared bfloat16 definitions: field widths, special constants, operand classes
// and the pipeline slot records used by the multiplier back end.
package bfloat_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 7;
    localparam int unsigned PROD_W = 14;
    localparam int unsigned SIG_W  = 16;
    localparam int unsigned XEXP_W = 10;

    localparam logic signed [XEXP_W-1:0] BF_BIAS    = 10'sd127;
    localparam logic signed [XEXP_W-1:0] BF_EXP_MAX = 10'sd255;
    localparam logic [15:0]              BF_QNAN    = 16'h7FC0;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } bf_class_e;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [EXP_W-1:0]  ea;
        logic [EXP_W-1:0]  eb;
        logic [FRAC_W-1:0] fa;
        logic [FRAC_W-1:0] fb;
        bf_class_e         cls_a;
        bf_class_e         cls_b;
    } bf_slot_t;

    typedef struct packed {
        logic              valid;
        logic              sign;
        logic [SIG_W-1:0]  sig;
        logic [XEXP_W-1:0] exp;    // two's complement, reinterpreted as signed downstream
        logic              invalid;
        logic              inf;
        logic              zero;
    } bf_stage_a_t;

    // Denormals are flushed: any zero exponent counts as zero.
    function automatic bf_class_e bf_classify(input logic [15:0] x);
        bf_class_e cls;
        cls = CLS_NORMAL;
        if (x[14:7] == '0) begin
            cls = CLS_ZERO;
        end else if (x[14:7] == '1) begin
            cls = (x[6:0] == '0) ? CLS_INF : CLS_NAN;
        end
        return cls;
    endfunction

endpackage

// File: rtl/bfloat_round_rne.sv
// Combinational normalize + round-to-nearest-even of a 16-bit significand
// product (1.xx or 1x.xx form) to a 7-bit bfloat fraction.
module bfloat_round_rne
    import bfloat_pkg::*;
(
    input  logic [SIG_W-1:0]         sig,
    input  logic signed [XEXP_W-1:0] exp,
    output logic [FRAC_W-1:0]        m,
    output logic signed [XEXP_W-1:0] exp_adj
);

    logic [FRAC_W-1:0]        m_raw;
    logic                     guard;
    logic                     sticky;
    logic                     inc;
    logic signed [XEXP_W-1:0] exp_n;

    always_comb begin
        m_raw  = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp_n  = exp;
        if (sig[15]) begin
            m_raw  = sig[14:8];
            guard  = sig[7];
            sticky = |sig[6:0];
            exp_n  = exp + 10'sd1;
        end else begin
            m_raw  = sig[13:7];
            guard  = sig[6];
            sticky = |sig[5:0];
        end
        inc = guard & (sticky | m_raw[0]);
        m   = m_raw + {{(FRAC_W-1){1'b0}}, inc};
        // Fraction wrapping to zero means the significand rounded up to 2.0.
        exp_adj = (inc && (m_raw == '1)) ? exp_n + 10'sd1 : exp_n;
    end

endmodule

// File: rtl/bfloat_mult_normalize.sv
// bfloat16 multiplier back end: delays operand fields to meet the mantissa
// product, then normalizes, rounds and packs the result with status flags.
module bfloat_mult_normalize
    import bfloat_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       a,
    input  logic [15:0]       b,
    input  logic [PROD_W-1:0] frac_prod,
    output logic              out_valid,
    output logic [15:0]       out,
    output logic              overflow,
    output logic              underflow,
    output logic              invalid
);

    bf_slot_t    dl_d [MULT_LAT];
    bf_slot_t    dl_q [MULT_LAT];
    bf_stage_a_t sa_d;
    bf_stage_a_t sa_q;

    logic [FRAC_W-1:0]        rnd_m;
    logic signed [XEXP_W-1:0] rnd_exp;

    logic        out_valid_d, out_valid_q;
    logic [15:0] out_d, out_q;
    logic        overflow_d, overflow_q;
    logic        underflow_d, underflow_q;
    logic        invalid_d, invalid_q;

    // Operand delay line, aligned with the mantissa multiplier latency.
    always_comb begin
        dl_d[0].valid = in_valid;
        dl_d[0].sign  = a[15] ^ b[15];
        dl_d[0].ea    = a[14:7];
        dl_d[0].eb    = b[14:7];
        dl_d[0].fa    = a[6:0];
        dl_d[0].fb    = b[6:0];
        dl_d[0].cls_a = bf_classify(a);
        dl_d[0].cls_b = bf_classify(b);
        for (int unsigned i = 1; i < MULT_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < MULT_LAT; i++) begin
            dl_q[i] <= dl_d[i];
        end
        if (rst) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                dl_q[i].valid <= 1'b0;
            end
        end
    end

    // Stage A: merge frac_prod into the full significand (128+fa)(128+fb).
    always_comb begin
        bf_slot_t s;
        logic [EXP_W:0] fsum;
        s    = dl_q[MULT_LAT-1];
        fsum = {1'b0, s.fa} + {1'b0, s.fb};
        sa_d.valid   = s.valid;
        sa_d.sign    = s.sign;
        sa_d.sig     = 16'h4000 + {1'b0, fsum, 7'd0} + {2'b00, frac_prod};
        sa_d.exp     = {2'b00, s.ea} + {2'b00, s.eb} - BF_BIAS;
        sa_d.invalid = (s.cls_a == CLS_NAN) || (s.cls_b == CLS_NAN) ||
                       (((s.cls_a == CLS_INF) || (s.cls_b == CLS_INF)) &&
                        ((s.cls_a == CLS_ZERO) || (s.cls_b == CLS_ZERO)));
        sa_d.inf     = (s.cls_a == CLS_INF) || (s.cls_b == CLS_INF);
        sa_d.zero    = (s.cls_a == CLS_ZERO) || (s.cls_b == CLS_ZERO);
    end

    always_ff @(posedge clk) begin
        sa_q <= sa_d;
        if (rst) begin
            sa_q.valid <= 1'b0;
        end
    end

    bfloat_round_rne u_round (
        .sig     (sa_q.sig),
        .exp     ($signed(sa_q.exp)),
        .m       (rnd_m),
        .exp_adj (rnd_exp)
    );

    // Stage B: special-case priority and packing; bubbles emit all zeros.
    always_comb begin
        out_valid_d = sa_q.valid;
        out_d       = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        invalid_d   = 1'b0;
        if (sa_q.valid) begin
            if (sa_q.invalid) begin
                out_d     = BF_QNAN;
                invalid_d = 1'b1;
            end else if (sa_q.inf) begin
                out_d = {sa_q.sign, 8'hFF, 7'h00};
            end else if (sa_q.zero) begin
                out_d = {sa_q.sign, 15'h0000};
            end else if (rnd_exp >= BF_EXP_MAX) begin
                out_d      = {sa_q.sign, 8'hFF, 7'h00};
                overflow_d = 1'b1;
            end else if (rnd_exp <= 10'sd0) begin
                out_d       = {sa_q.sign, 15'h0000};
                underflow_d = 1'b1;
            end else begin
                out_d = {sa_q.sign, rnd_exp[7:0], rnd_m};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            invalid_q   <= invalid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign invalid   = invalid_q;

endmodule
